// File: rtl/serial_matvec_engine_pkg.sv
// Shared definitions for the serial matrix-vector engine: command codes,
// memory request encodings, FSM state encoding and the error payload.
package serial_matvec_engine_pkg;

  // Command function codes
  localparam logic [6:0] CFG_X   = 7'd0;
  localparam logic [6:0] CFG_W   = 7'd1;
  localparam logic [6:0] CFG_Y   = 7'd2;
  localparam logic [6:0] CFG_DIM = 7'd3;
  localparam logic [6:0] START   = 7'd4;

  // Memory request command / size encodings
  localparam logic [4:0] M_LD  = 5'd0;
  localparam logic [4:0] M_ST  = 5'd1;
  localparam logic [2:0] TYP_D = 3'd3;
  localparam logic [2:0] TYP_W = 3'd2;

  // Response payload for a rejected START
  localparam logic [31:0] ERR_CODE = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDX_REQ,
    S_LDX_WAIT,
    S_ROW_REQ,
    S_ROW_WAIT,
    S_MAC,
    S_ST_REQ,
    S_ST_WAIT,
    S_RESP
  } state_t;

  // Number of 8-byte doublewords covering one row of cols byte elements
  function automatic logic [5:0] dwords_for(input logic [7:0] cols);
    logic [8:0] t;
    t = {1'b0, cols} + 9'd7;
    return t[8:3];
  endfunction

endpackage

// File: rtl/serial_matvec_mac.sv
// Serial multiply-accumulate: picks one signed byte lane of the current W
// doubleword, multiplies by the matching X element and accumulates with
// wrap-around. acc_next is exposed so the last product of a row can be
// stored in the same cycle it is accumulated.
module serial_matvec_mac
  import serial_matvec_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [63:0]              w_dword,
  input  logic [2:0]               lane,
  input  logic signed [DATA_W-1:0] x_val,
  output logic signed [ACC_W-1:0]  acc_next
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   w_val;
  logic signed [2*DATA_W-1:0] prod;

  // Lane select, full-precision signed product and wrapping sum
  always_comb begin
    w_val    = w_dword[lane*DATA_W +: DATA_W];
    prod     = w_val * x_val;
    acc_next = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  // Accumulator register; clear wins over enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/serial_matvec_engine.sv
// Command-driven y = W*x engine. Loads x into a local register file, then
// streams W one doubleword at a time, multiplies one byte lane per cycle and
// stores each 32-bit row result (optionally ReLU-clamped).
//
// Handshakes: a transfer happens on the clock edge where valid && ready are
// both high. Request-side valid and payload are registered and held
// unchanged until that edge; at most one memory request is outstanding, and
// memory responses are only looked at in the *_WAIT states.
module serial_matvec_engine
  import serial_matvec_engine_pkg::*;
#(
  parameter int K_MAX  = 16,
  parameter int N_MAX  = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 40
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [63:0]       cmd_rs1_i,
  input  logic [6:0]        cmd_inst_funct_i,
  input  logic [4:0]        cmd_inst_rd_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [4:0]        mem_req_cmd_o,
  output logic [2:0]        mem_req_typ_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [63:0]       mem_req_data_o,
  input  logic              mem_resp_valid_i,
  input  logic [4:0]        mem_resp_cmd_i,
  input  logic [63:0]       mem_resp_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [4:0]        resp_rd_o,
  output logic [31:0]       resp_data_o,
  output state_t            dbg_state_o
);

  localparam int XI_W = $clog2(K_MAX);

  state_t                    state;
  logic [ADDR_W-1:0]         x_base, w_base, y_base;
  logic [ADDR_W-1:0]         row_addr, y_addr;
  logic [7:0]                rows, cols;
  logic [7:0]                i_cnt, j_cnt, r_cnt;
  logic [2:0]                lane;
  logic                      relu_en;
  logic [4:0]                rd_q;
  logic [63:0]               w_dword;
  logic signed [DATA_W-1:0]  x_rf [K_MAX];

  logic [5:0]                n_dw;
  logic [ADDR_W-1:0]         row_stride;
  logic [7:0]                col;
  logic                      last_col, last_lane;
  logic signed [DATA_W-1:0]  x_sel;
  logic                      mac_clr, mac_en, st_done, cfg_ok;
  logic signed [ACC_W-1:0]   acc_next;
  logic [31:0]               y_val;
  logic                      unused_bits;

  assign dbg_state_o = state;
  assign unused_bits = ^cmd_rs1_i[63:ADDR_W];

  // Row geometry, column tracking, MAC control and the value to store
  always_comb begin
    n_dw       = dwords_for(cols);
    row_stride = ADDR_W'({n_dw, 3'b000});
    col        = {j_cnt[4:0], lane};
    last_col   = (col == cols - 8'd1);
    last_lane  = (lane == 3'd7) || last_col;
    x_sel      = x_rf[col[XI_W-1:0]];
    mac_en     = (state == S_MAC);
    st_done    = (state == S_ST_WAIT) && mem_resp_valid_i && (mem_resp_cmd_i == M_ST);
    mac_clr    = (state == S_IDLE) || st_done;
    y_val      = (relu_en && acc_next[ACC_W-1]) ? 32'd0 : acc_next[31:0];
    cfg_ok     = (rows != 8'd0) && (cols != 8'd0) &&
                 (rows <= 8'(N_MAX)) && (cols <= 8'(K_MAX));
  end

  serial_matvec_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .w_dword  (w_dword),
    .lane     (lane),
    .x_val    (x_sel),
    .acc_next (acc_next)
  );

  // Control FSM with registered command, memory and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      cmd_ready_o     <= 1'b1;
      mem_req_valid_o <= 1'b0;
      mem_req_cmd_o   <= '0;
      mem_req_typ_o   <= '0;
      mem_req_addr_o  <= '0;
      mem_req_data_o  <= '0;
      resp_valid_o    <= 1'b0;
      resp_rd_o       <= '0;
      resp_data_o     <= '0;
      x_base          <= '0;
      w_base          <= '0;
      y_base          <= '0;
      row_addr        <= '0;
      y_addr          <= '0;
      rows            <= '0;
      cols            <= '0;
      i_cnt           <= '0;
      j_cnt           <= '0;
      r_cnt           <= '0;
      lane            <= '0;
      relu_en         <= 1'b0;
      rd_q            <= '0;
      w_dword         <= '0;
      for (int k = 0; k < K_MAX; k++) x_rf[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            case (cmd_inst_funct_i)
              CFG_X:   x_base <= cmd_rs1_i[ADDR_W-1:0];
              CFG_W:   w_base <= cmd_rs1_i[ADDR_W-1:0];
              CFG_Y:   y_base <= cmd_rs1_i[ADDR_W-1:0];
              CFG_DIM: begin
                rows <= cmd_rs1_i[7:0];
                cols <= cmd_rs1_i[15:8];
              end
              START: begin
                relu_en     <= cmd_rs1_i[0];
                rd_q        <= cmd_inst_rd_i;
                cmd_ready_o <= 1'b0;
                if (!cfg_ok) begin
                  state        <= S_RESP;
                  resp_valid_o <= 1'b1;
                  resp_data_o  <= ERR_CODE;
                  resp_rd_o    <= cmd_inst_rd_i;
                end else begin
                  state           <= S_LDX_REQ;
                  i_cnt           <= '0;
                  mem_req_valid_o <= 1'b1;
                  mem_req_cmd_o   <= M_LD;
                  mem_req_typ_o   <= TYP_D;
                  mem_req_addr_o  <= x_base;
                  mem_req_data_o  <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        S_LDX_REQ, S_ROW_REQ, S_ST_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state <= (state == S_LDX_REQ) ? S_LDX_WAIT :
                     (state == S_ROW_REQ) ? S_ROW_WAIT : S_ST_WAIT;
          end
        end
        S_LDX_WAIT: begin
          if (mem_resp_valid_i) begin
            for (int k = 0; k < 8; k++)
              x_rf[XI_W'(i_cnt * 8 + k)] <= mem_resp_data_i[k*DATA_W +: DATA_W];
            mem_req_valid_o <= 1'b1;
            mem_req_cmd_o   <= M_LD;
            mem_req_typ_o   <= TYP_D;
            mem_req_data_o  <= '0;
            if (i_cnt == 8'(n_dw) - 8'd1) begin
              state          <= S_ROW_REQ;
              r_cnt          <= '0;
              j_cnt          <= '0;
              row_addr       <= w_base;
              y_addr         <= y_base;
              mem_req_addr_o <= w_base;
            end else begin
              state          <= S_LDX_REQ;
              i_cnt          <= i_cnt + 8'd1;
              mem_req_addr_o <= x_base + ADDR_W'({i_cnt + 8'd1, 3'b000});
            end
          end
        end
        S_ROW_WAIT: begin
          if (mem_resp_valid_i) begin
            w_dword <= mem_resp_data_i;
            lane    <= '0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          if (last_lane) begin
            mem_req_valid_o <= 1'b1;
            if (last_col) begin
              state          <= S_ST_REQ;
              mem_req_cmd_o  <= M_ST;
              mem_req_typ_o  <= TYP_W;
              mem_req_addr_o <= y_addr;
              mem_req_data_o <= {{32{y_val[31]}}, y_val};
            end else begin
              state          <= S_ROW_REQ;
              j_cnt          <= j_cnt + 8'd1;
              mem_req_cmd_o  <= M_LD;
              mem_req_typ_o  <= TYP_D;
              mem_req_addr_o <= row_addr + ADDR_W'({j_cnt + 8'd1, 3'b000});
              mem_req_data_o <= '0;
            end
          end else begin
            lane <= lane + 3'd1;
          end
        end
        S_ST_WAIT: begin
          if (st_done) begin
            r_cnt    <= r_cnt + 8'd1;
            j_cnt    <= '0;
            y_addr   <= y_addr + ADDR_W'(4);
            row_addr <= row_addr + row_stride;
            if (r_cnt + 8'd1 == rows) begin
              state        <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_data_o  <= 32'(rows);
              resp_rd_o    <= rd_q;
            end else begin
              state           <= S_ROW_REQ;
              mem_req_valid_o <= 1'b1;
              mem_req_cmd_o   <= M_LD;
              mem_req_typ_o   <= TYP_D;
              mem_req_addr_o  <= row_addr + row_stride;
              mem_req_data_o  <= '0;
            end
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            cmd_ready_o  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_matvec_engine.md
Name: serial_matvec_engine

Overview:
Parametrised successor to the serial matmul accelerator: a command-driven engine computing y = W·x for a ROWS×COLS signed matrix W and signed vector x, both in memory.
- Sits between the processor command/response interface and the 64-bit data memory port.
- Loads x into a local X register file, then streams W row by row and multiplies serially, one byte lane per cycle.
- Writes each 32-bit result to memory, with optional ReLU.
- Dimensions and base addresses are runtime-configured.

Parameters:
K_MAX, 16, max columns (X register file entries); multiple of 8
N_MAX, 16, max rows accepted
DATA_W, 8, signed element width
ACC_W, 32, signed accumulator width (≥ 2*DATA_W)
ADDR_W, 40, memory address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accept
cmd_rs1_i  in  64  command operand
cmd_inst_funct_i  in  7  command code
cmd_inst_rd_i  in  5  destination register for response
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory request accept
mem_req_cmd_o  out  5  0=load, 1=store
mem_req_typ_o  out  3  3=doubleword, 2=word
mem_req_addr_o  out  ADDR_W  byte address
mem_req_data_o  out  64  store data (result in [31:0], sign-extended)
mem_resp_valid_i  in  1  memory response valid
mem_resp_cmd_i  in  5  echoed command
mem_resp_data_i  in  64  load data (little-endian byte lanes)
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response accept
resp_rd_o  out  5  response destination register
resp_data_o  out  32  response payload

Behaviour:
- Reset values (on reset_n low, asynchronous): state=IDLE, cmd_ready_o=1, all valids=0, all data/address outputs=0, config registers=0.
- Handshake: every transfer occurs on valid&&ready.
  - Request outputs hold stable until accepted.
  - Exactly one memory request is outstanding at a time.
  - mem_resp_valid_i is ignored outside WAIT states.
- Commands (accepted only in IDLE; cmd_ready_o=1 only in IDLE):
  - funct 0: X base ← rs1[ADDR_W-1:0]
  - funct 1: W base ← rs1[ADDR_W-1:0]
  - funct 2: Y base ← rs1[ADDR_W-1:0]
  - funct 3: rows ← rs1[7:0], cols ← rs1[15:8]
  - funct 4: START; relu_en ← rs1[0]; rd latched.
  - Other functs are accepted and ignored.
  - Only START produces a response.
- START validation:
  - If rows=0, cols=0, rows>N_MAX or cols>K_MAX: go to RESP with data 32'hFFFF_FFFF.
  - Otherwise go to LDX_REQ.
- FSM states:
  - LDX_REQ: load doubleword at X base + 8*i.
  - LDX_WAIT: on load response, write lanes 0..7 into X entries 8i..8i+7. Repeat for i = 0..ceil(cols/8)-1, then go to ROW_REQ with r=0, acc=0.
  - ROW_REQ: load W doubleword at W base + r*ceil(cols/8)*8 + 8*j (rows are padded to 8-byte stride).
  - ROW_WAIT: on response, latch the doubleword and go to MAC.
  - MAC: one lane per cycle, acc += sext(W lane) * sext(X[8j+lane]). Lanes stop at the earlier of lane 7 and column cols-1. Then next j (ROW_REQ) or, at end of row, go to ST_REQ.
  - ST_REQ: store word at Y base + 4r. Data = relu_en && acc<0 ? 0 : acc[31:0].
  - ST_WAIT: wait for a response with cmd=1. Then r++, acc=0; if r==rows go to RESP, else ROW_REQ.
  - RESP: resp_valid_o=1, data=rows, rd=latched rd. Holds until resp_ready_i, then IDLE.
- Arithmetic: products are 2*DATA_W signed. The accumulator wraps modulo 2^ACC_W with no saturation.
- Latency:
  - Per W doubleword: 1 request cycle (when ready) + memory latency + up to 8 MAC cycles.
  - Per row: one extra store round trip.
- Back-pressure:
  - mem_req_ready_i low: remain in the REQ state.
  - resp_ready_i low: remain in RESP. A new command cannot be accepted until the response handshake completes.
- Reset mid-operation: the job is abandoned immediately. No response is issued, and a pending memory response after reset is ignored.
- Simultaneous events: a memory response and a request-ready in the same cycle cannot conflict, because there is a single outstanding request.

Decomposition:
- Shared package holds:
  - funct codes (CFG_X, CFG_W, CFG_Y, CFG_DIM, START)
  - memory cmd/typ constants (M_LD=0, M_ST=1, TYP_D=3, TYP_W=2)
  - the FSM state enum
  - the error code 32'hFFFF_FFFF
- One sub-module: serial_matvec_mac, which does lane select, signed multiply and accumulate with clear and enable; the FSM stays in the top module.

Test Plan:
- 2×8 case: X=[1..8], W row0=all 1, row1=all -1, relu off → stores 36 at Y, -36 (32'hFFFF_FFDC) at Y+4; response data=2, rd echoed.
- Same job with relu_en=1 → stores 36 and 0.
- cols=11, rows=3, X=all 2, W=all 3 → two doubleword loads per row, W row stride 16 bytes, each result 66; 3 stores at Y, Y+4, Y+8.
- START with cols=K_MAX+1 → no memory traffic; response 32'hFFFF_FFFF on the next cycle; cmd_ready_o=0 until resp_ready_i.
- Random mem_req_ready_i/mem_resp delays and resp_ready_i held low 5 cycles → same results as the zero-delay run; request outputs stable while stalled; a second START is not accepted before the response handshake.
- Overflow and reset: W=X=all -128 with K_MAX=16 → 16*16384 = 262144 stored exactly. Asserting reset_n low mid-row → outputs at reset values immediately; a later START runs cleanly.
